block_allocator: RTL and testbench
==================================

BLOCK_ALLOCATOR -- requirements
Module: block_allocator

Interface
REQ-001 Parameter BLOCKS, default 64, number of managed blocks; SHALL be a power of two and at least 4.
REQ-002 Clocking SHALL be one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 free_bitmap  input  BLOCKS  pool state; bit i = 1 means block i is free.
REQ-006 req  input  1  requester asks for one free block.
REQ-007 req_ready  output  1  high only in IDLE; a request is accepted on a cycle where req and req_ready are both high.
REQ-008 grant_valid  output  1  grant_block is valid and held.
REQ-009 grant_block  output  $clog2(BLOCKS)  granted block index.
REQ-010 grant_ready  input  1  requester accepts the grant.
REQ-011 alloc_fail  output  1  one-cycle pulse: no free block was found.
REQ-012 allocate  output  1  one-cycle pulse to the pool marking alloc_block used.
REQ-013 alloc_block  output  $clog2(BLOCKS)  block index accompanying allocate.
REQ-014 free_count  output  $clog2(BLOCKS)+1  registered popcount of free_bitmap.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SCAN, GRANT and COMMIT.
REQ-016 IDLE SHALL move to SCAN on req and req_ready; otherwise it stays in IDLE.
REQ-017 SCAN SHALL last exactly one cycle and sample free_bitmap in that cycle.
REQ-018 If SCAN finds a free block, the FSM SHALL go to GRANT with grant_block registered from the search result.
REQ-019 If free_bitmap is all zero in SCAN, alloc_fail SHALL pulse in the next cycle and the FSM SHALL return to IDLE without a grant.
REQ-020 Latency SHALL be fixed: request accepted in cycle N gives grant_valid, or the alloc_fail pulse, in cycle N+2.
REQ-021 grant_valid and grant_block SHALL stay stable in GRANT until grant_valid and grant_ready are both high; there is no timeout.
REQ-022 On that handshake the FSM SHALL enter COMMIT, driving allocate=1 and alloc_block=grant_block for exactly one cycle, then IDLE.
REQ-023 The pool clears the bit at the end of the COMMIT cycle, so the next SCAN SHALL see the updated bitmap and never grant the same block twice.
REQ-024 allocate SHALL never be asserted outside COMMIT.
REQ-025 A req held high continuously SHALL be re-accepted at each return to IDLE (back-to-back allocations every 4 cycles).
REQ-026 Changes to free_bitmap in GRANT (frees) SHALL NOT alter the held grant.
REQ-027 free_count SHALL update every cycle to the popcount of the previous cycle's free_bitmap.
REQ-028 free_count SHALL represent BLOCKS without overflow.

Reset
REQ-029 Reset SHALL force IDLE from any state, including mid-GRANT or in COMMIT.
REQ-030 Reset values SHALL be: req_ready=1, grant_valid=0, grant_block=0, alloc_fail=0, allocate=0, alloc_block=0, free_count=0, search pointer=0.
REQ-031 A grant pending at reset SHALL be dropped, with no allocate pulse.

Configuration
REQ-032 The macro ALLOC_ROUND_ROBIN_EN SHALL select the search order.
REQ-033 With ALLOC_ROUND_ROBIN_EN defined, the search SHALL start at the search pointer and wrap from BLOCKS-1 to 0, choosing the first free block.
REQ-034 With ALLOC_ROUND_ROBIN_EN defined, the pointer SHALL be set to (alloc_block+1) mod BLOCKS in COMMIT.
REQ-035 With ALLOC_ROUND_ROBIN_EN undefined, the lowest-index free block SHALL be chosen and no pointer register SHALL exist.

Verification
REQ-036 BLOCKS=8, bitmap 8'hFF, req with grant_ready=1 -> grant_block=0 at N+2; allocate with alloc_block=0 at N+3; free_count=8.
REQ-037 Bitmap 8'h00, req -> alloc_fail pulse at N+2; no grant_valid and no allocate.
REQ-038 Bitmap 8'b1010_0000, grant_ready held low 5 cycles -> grant_block=5 stable throughout; allocate only after grant_ready rises.
REQ-039 Round robin on, bitmap 8'hFF, three back-to-back grants with the pool model attached, then free block 0 -> grants 0, 1, 2; next grant 3, not 0; round robin off gives 0.
REQ-040 Round robin on, pointer=7, bitmap 8'b0000_0011 -> grant_block=0 (wrap-around).
REQ-041 Reset asserted in GRANT -> next cycle grant_valid=0, req_ready=1, no allocate pulse.

Source files
------------

// File: rtl/block_allocator_if.sv
// rtl/block_allocator_if.sv - request/grant/allocate bundle between requester, pool and block_allocator
interface block_allocator_if #(
  parameter int BLOCKS = 64
);
  localparam int IW = $clog2(BLOCKS);

  logic [BLOCKS-1:0] free_bitmap;
  logic              req;
  logic              req_ready;
  logic              grant_valid;
  logic [IW-1:0]     grant_block;
  logic              grant_ready;
  logic              alloc_fail;
  logic              allocate;
  logic [IW-1:0]     alloc_block;
  logic [IW:0]       free_count;

  modport slave (
    input  free_bitmap, req, grant_ready,
    output req_ready, grant_valid, grant_block, alloc_fail, allocate, alloc_block, free_count
  );

  modport master (
    output free_bitmap, req, grant_ready,
    input  req_ready, grant_valid, grant_block, alloc_fail, allocate, alloc_block, free_count
  );
endinterface

// File: rtl/block_allocator.sv
// rtl/block_allocator.sv - single-block allocator over a free bitmap, fixed two-cycle grant latency
// Optional ALLOC_ROUND_ROBIN_EN: search from a rotating pointer instead of lowest index.
module block_allocator #(
  parameter int BLOCKS = 64
) (
  input  logic              clk,
  input  logic              reset,
  block_allocator_if.slave  bus
);
  localparam int IW = $clog2(BLOCKS);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {IDLE, SCAN, GRANT, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_block_q, grant_block_d;
  logic          alloc_fail_q, alloc_fail_d;
  logic [CW-1:0] free_count_q, free_count_d;
  logic          found;
  logic [IW-1:0] hit;
  logic [IW-1:0] idx;

`ifdef ALLOC_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Walk offsets high to low so the smallest offset from the pointer wins.
  always_comb begin
    found = 1'b0;
    hit   = '0;
    idx   = '0;
    for (int i = BLOCKS - 1; i >= 0; i--) begin
      idx = ptr_q + IW'(i);
      if (bus.free_bitmap[idx]) begin
        found = 1'b1;
        hit   = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == COMMIT) ptr_d = grant_block_q + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    found = 1'b0;
    hit   = '0;
    idx   = '0;
    for (int i = BLOCKS - 1; i >= 0; i--) begin
      idx = IW'(i);
      if (bus.free_bitmap[idx]) begin
        found = 1'b1;
        hit   = idx;
      end
    end
  end
`endif

  always_comb begin
    free_count_d = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      free_count_d = free_count_d + {{(CW-1){1'b0}}, bus.free_bitmap[i]};
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_block_d = grant_block_q;
    alloc_fail_d  = 1'b0;
    case (state_q)
      IDLE:   if (bus.req) state_d = SCAN;
      SCAN: begin
        if (found) begin
          state_d       = GRANT;
          grant_block_d = hit;
        end else begin
          state_d      = IDLE;
          alloc_fail_d = 1'b1;
        end
      end
      // The grant is held against later bitmap changes until the requester takes it.
      GRANT:  if (bus.grant_ready) state_d = COMMIT;
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_block_q <= '0;
      alloc_fail_q  <= 1'b0;
      free_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_block_q <= grant_block_d;
      alloc_fail_q  <= alloc_fail_d;
      free_count_q  <= free_count_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.grant_valid = (state_q == GRANT);
  assign bus.grant_block = grant_block_q;
  assign bus.alloc_fail  = alloc_fail_q;
  assign bus.allocate    = (state_q == COMMIT);
  assign bus.alloc_block = (state_q == COMMIT) ? grant_block_q : '0;
  assign bus.free_count  = free_count_q;
endmodule

// File: tb/tb_block_allocator.sv
// tb/tb_block_allocator.sv - directed self-checking bench for block_allocator with BLOCKS=8
module tb_block_allocator;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic pool_en = 1'b0;

  block_allocator_if #(.BLOCKS(8)) bus ();

  block_allocator #(.BLOCKS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; the pool model clears the committed block at the edge.
  task automatic tick();
    logic       a;
    logic [2:0] b;
    a = bus.allocate;
    b = bus.alloc_block;
    @(posedge clk);
    #1;
    if (pool_en && a) bus.free_bitmap[b] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int exp4;

  initial begin
    reset           = 1'b1;
    bus.req         = 1'b0;
    bus.grant_ready = 1'b0;
    bus.free_bitmap = 8'hFF;
    tick();
    tick();
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_grant_valid", bus.grant_valid, 0);
    check("rst_grant_block", bus.grant_block, 0);
    check("rst_alloc_fail", bus.alloc_fail, 0);
    check("rst_allocate", bus.allocate, 0);
    check("rst_alloc_block", bus.alloc_block, 0);
    check("rst_free_count", bus.free_count, 0);
    reset = 1'b0;
    tick();
    check("free_count_full", bus.free_count, 8);

    // All free, ready high: grant 0 at N+2, allocate 0 at N+3
    bus.grant_ready = 1'b1;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    check("a_scan_no_grant", bus.grant_valid, 0);
    tick();
    check("a_grant_valid", bus.grant_valid, 1);
    check("a_grant_block", bus.grant_block, 0);
    check("a_no_alloc_in_grant", bus.allocate, 0);
    tick();
    check("a_allocate", bus.allocate, 1);
    check("a_alloc_block", bus.alloc_block, 0);
    check("a_free_count", bus.free_count, 8);
    tick();
    check("a_back_idle", bus.req_ready, 1);
    check("a_alloc_once", bus.allocate, 0);

    // Empty pool: alloc_fail pulse at N+2, no grant or allocate
    bus.free_bitmap = 8'h00;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    check("b_fail_early", bus.alloc_fail, 0);
    tick();
    check("b_alloc_fail", bus.alloc_fail, 1);
    check("b_no_grant", bus.grant_valid, 0);
    check("b_no_alloc", bus.allocate, 0);
    check("b_ready", bus.req_ready, 1);
    check("b_free_count", bus.free_count, 0);
    tick();
    check("b_fail_pulse", bus.alloc_fail, 0);

    // Grant held while ready low; frees in GRANT do not alter it
    bus.free_bitmap = 8'b1010_0000;
    bus.grant_ready = 1'b0;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    tick();
    check("c_free_count", bus.free_count, 2);
    for (int i = 0; i < 5; i++) begin
      check("c_hold_valid", bus.grant_valid, 1);
      check("c_hold_block", bus.grant_block, 5);
      check("c_hold_no_alloc", bus.allocate, 0);
      if (i == 2) bus.free_bitmap = 8'hFF;
      tick();
    end
    check("c_still_block", bus.grant_block, 5);
    bus.grant_ready = 1'b1;
    tick();
    check("c_allocate", bus.allocate, 1);
    check("c_alloc_block", bus.alloc_block, 5);
    tick();

    // Back-to-back with pool attached, then free block 0
    do_reset();
    bus.free_bitmap = 8'hFF;
    pool_en = 1'b1;
    bus.grant_ready = 1'b1;
    bus.req = 1'b1;
`ifdef ALLOC_ROUND_ROBIN_EN
    exp4 = 3;
`else
    exp4 = 0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.free_bitmap[0] = 1'b1;
      check("d_accept", bus.req_ready, 1);
      tick();
      tick();
      if (k == 3) bus.req = 1'b0;
      check("d_grant_valid", bus.grant_valid, 1);
      check("d_grant_block", bus.grant_block, (k == 3) ? exp4 : k);
      tick();
      check("d_allocate", bus.allocate, 1);
      tick();
    end
    check("d_bitmap", bus.free_bitmap, (exp4 == 3) ? 8'hF1 : 8'hF8);
    pool_en = 1'b0;

    // Pointer to 7 via a grant of block 6, then wrap to block 0
    bus.free_bitmap = 8'b0100_0000;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    tick();
    check("e_grant6", bus.grant_block, 6);
    tick();
    tick();
    bus.free_bitmap = 8'b0000_0011;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    tick();
    check("e_wrap_valid", bus.grant_valid, 1);
    check("e_wrap_block", bus.grant_block, 0);
    tick();
    tick();

    // Reset in GRANT drops the grant without allocating
    bus.grant_ready = 1'b0;
    bus.free_bitmap = 8'h10;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    tick();
    check("f_in_grant", bus.grant_valid, 1);
    check("f_grant_block", bus.grant_block, 4);
    reset = 1'b1;
    bus.grant_ready = 1'b1;
    tick();
    check("f_rst_valid", bus.grant_valid, 0);
    check("f_rst_ready", bus.req_ready, 1);
    check("f_rst_alloc", bus.allocate, 0);
    check("f_rst_block", bus.grant_block, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("f_no_alloc_after", bus.allocate, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
